// File: rtl/fir_feed_ctrl_pkg.sv
// Shared constants and state encoding for the FIR feed sequencer.
// Optional macro FIR_FEED_SAMPLE_CNT_EN is consumed by fir_feed_ctrl.
package fir_feed_ctrl_pkg;
  localparam int OPERAND_SIZE = 8;
  localparam int COEF_IDX_W   = 2;
  localparam int CNT_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;
endpackage

// File: rtl/fir_coef_bank.sv
// Three coefficient registers loaded round-robin through a write strobe;
// loaded is high only while a complete c0,c1,c2 set is held.
module fir_coef_bank
  import fir_feed_ctrl_pkg::*;
#(
  parameter int W = OPERAND_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] c0_o,
  output logic [W-1:0] c1_o,
  output logic [W-1:0] c2_o,
  output logic         loaded_o
);
  logic [W-1:0]          c0_q, c1_q, c2_q;
  logic [COEF_IDX_W-1:0] idx_q;
  logic                  loaded_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0_q     <= '0;
      c1_q     <= '0;
      c2_q     <= '0;
      idx_q    <= '0;
      loaded_q <= 1'b0;
    end else if (we_i) begin
      case (idx_q)
        2'd0: begin
          c0_q     <= wdata_i;
          idx_q    <= 2'd1;
          loaded_q <= 1'b0;  // a new set has begun
        end
        2'd1: begin
          c1_q  <= wdata_i;
          idx_q <= 2'd2;
        end
        default: begin
          c2_q     <= wdata_i;
          idx_q    <= 2'd0;
          loaded_q <= 1'b1;
        end
      endcase
    end
  end

  assign c0_o     = c0_q;
  assign c1_o     = c1_q;
  assign c2_o     = c2_q;
  assign loaded_o = loaded_q;
endmodule

// File: rtl/fir_feed_ctrl.sv
// Front-end sequencer for a 3-tap transposed FIR: coefficient load, frame
// streaming, two-cycle zero drain. `FIR_FEED_SAMPLE_CNT_EN adds frame_cnt.
module fir_feed_ctrl
  import fir_feed_ctrl_pkg::*;
#(
  parameter int W = OPERAND_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         coef_valid,
  input  logic [W-1:0] coef_data,
  output logic         coef_ready,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         s_ready,
  output logic [W-1:0] x,
  output logic [W-1:0] c0,
  output logic [W-1:0] c1,
  output logic [W-1:0] c2,
  output logic         y_valid,
  output logic         y_last,
`ifdef FIR_FEED_SAMPLE_CNT_EN
  output logic [CNT_W-1:0] frame_cnt,
`endif
  output logic         busy
);
  state_e       state_q;
  logic [W-1:0] x_q;
  logic         y_valid_q, y_last_q;
  logic         loaded;
  logic         coef_we, s_accept;

  assign coef_ready = (state_q == ST_IDLE);
  assign coef_we    = coef_valid & coef_ready;
  // Coefficient writes win over starting a frame.
  assign s_ready    = ((state_q == ST_IDLE) & loaded & ~coef_valid) | (state_q == ST_RUN);
  assign s_accept   = s_valid & s_ready;
  assign busy       = (state_q != ST_IDLE);

  fir_coef_bank #(.W(W)) u_bank (
    .clk      (clk),
    .rst      (rst),
    .we_i     (coef_we),
    .wdata_i  (coef_data),
    .c0_o     (c0),
    .c1_o     (c1),
    .c2_o     (c2),
    .loaded_o (loaded)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          x_q       <= '0;
          y_valid_q <= 1'b0;
          y_last_q  <= 1'b0;
          if (s_accept) begin
            x_q       <= s_data;
            y_valid_q <= 1'b1;
            state_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          y_valid_q <= 1'b1;
          if (s_valid) begin
            x_q <= s_data;
          end else begin
            x_q     <= '0;  // first drain sample
            state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          x_q       <= '0;
          y_valid_q <= 1'b1;
          y_last_q  <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: begin
          x_q       <= '0;
          y_valid_q <= 1'b0;
          y_last_q  <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FIR_FEED_SAMPLE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (s_accept) begin
      if (state_q == ST_IDLE)
        cnt_q <= CNT_W'(1);
      else if (cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign frame_cnt = cnt_q;
`endif

  assign x       = x_q;
  assign y_valid = y_valid_q;
  assign y_last  = y_last_q;
endmodule

// File: tb/tb_fir_feed_ctrl.sv
// Directed bench for fir_feed_ctrl; a small transposed-FIR model turns x/c
// into y so expected filter outputs can be given as hand-computed constants.
module tb_fir_feed_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         coef_valid;
  logic [W-1:0] coef_data;
  logic         coef_ready;
  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_ready;
  logic [W-1:0] x, c0, c1, c2;
  logic         y_valid, y_last, busy;
`ifdef FIR_FEED_SAMPLE_CNT_EN
  logic [15:0]  frame_cnt;
`endif

  int checks = 0;
  int passes = 0;

  fir_feed_ctrl #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .coef_valid (coef_valid),
    .coef_data  (coef_data),
    .coef_ready (coef_ready),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .x          (x),
    .c0         (c0),
    .c1         (c1),
    .c2         (c2),
    .y_valid    (y_valid),
    .y_last     (y_last),
`ifdef FIR_FEED_SAMPLE_CNT_EN
    .frame_cnt  (frame_cnt),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Filter datapath stand-in: y = c2*x[n] + c1*x[n-1] + c0*x[n-2].
  logic [W-1:0] x1 = '0, x2 = '0;
  logic [15:0]  y;
  always @(posedge clk) begin
    x2 <= x1;
    x1 <= x;
  end
  assign y = 16'(c2) * 16'(x) + 16'(c1) * 16'(x1) + 16'(c0) * 16'(x2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; coef_valid = 1'b0; coef_data = '0; s_valid = 1'b0; s_data = '0;
    step(); step();
    chk("rst_x", x, 0);
    chk("rst_yv", y_valid, 0);
    chk("rst_yl", y_last, 0);
    chk("rst_c0", c0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sready", s_ready, 0);
    rst = 1'b0;
    step();

    // Sample offered before coefficients: held off until the set is complete.
    s_valid = 1'b1; s_data = 8'd1; coef_valid = 1'b1; coef_data = 8'd1;
    #1 chk("noload_sready0", s_ready, 0);
    chk("noload_cready", coef_ready, 1);
    step();
    coef_data = 8'd2;
    chk("noload_sready1", s_ready, 0);
    chk("noload_yv1", y_valid, 0);
    chk("load_c0", c0, 1);
    step();
    coef_data = 8'd3;
    chk("noload_sready2", s_ready, 0);
    chk("load_c1", c1, 2);
    step();
    coef_valid = 1'b0;
    #1 chk("loaded_sready", s_ready, 1);
    chk("load_c2", c2, 3);
    chk("loaded_yv0", y_valid, 0);

    // Frame 1,2,3 with c=(1,2,3): y = 3, 8, 14, 8, 3.
    step();
    chk("f123_x0", x, 1);
    chk("f123_yv0", y_valid, 1);
    chk("f123_y0", y, 3);
    chk("f123_yl0", y_last, 0);
    s_data = 8'd2;
    step();
    chk("f123_y1", y, 8);
    s_data = 8'd3;
    step();
    chk("f123_y2", y, 14);
    chk("f123_yv2", y_valid, 1);
    s_valid = 1'b0;
    step();
    chk("f123_y3", y, 8);
    chk("f123_yv3", y_valid, 1);
    chk("f123_yl3", y_last, 0);
    chk("flush_sready", s_ready, 0);
    chk("flush_busy", busy, 1);
    step();
    chk("f123_y4", y, 3);
    chk("f123_yv4", y_valid, 1);
    chk("f123_yl4", y_last, 1);
    step();
    chk("post_yv", y_valid, 0);
    chk("post_yl", y_last, 0);
    chk("post_busy", busy, 0);

    // Coefficient and sample offered together: coefficient wins.
    coef_valid = 1'b1; coef_data = 8'd1; s_valid = 1'b1; s_data = 8'd7;
    #1 chk("prio_sready", s_ready, 0);
    chk("prio_cready", coef_ready, 1);
    step();
    coef_valid = 1'b0;
    #1 chk("prio_c0", c0, 1);
    chk("prio_unloaded", s_ready, 0);
    chk("prio_yv", y_valid, 0);
    chk("prio_c1_kept", c1, 2);
    s_valid = 1'b0;
    coef_valid = 1'b1;
    step();
    step();
    coef_valid = 1'b0;
    #1 chk("reload_c1", c1, 1);
    chk("reload_c2", c2, 1);

    // Back-to-back frames [5] then [2] with c=(1,1,1).
    s_valid = 1'b1; s_data = 8'd5;
    step();
    chk("b5_y0", y, 5);
    chk("b5_yv0", y_valid, 1);
    s_valid = 1'b0;
    step();
    chk("b5_y1", y, 5);
    chk("b5_yl1", y_last, 0);
    step();
    chk("b5_y2", y, 5);
    chk("b5_yl2", y_last, 1);
    s_valid = 1'b1; s_data = 8'd2;
    #1 chk("b2b_sready", s_ready, 1);
    step();
    chk("b2_y0", y, 2);
    chk("b2_yl0", y_last, 0);
    chk("b2_yv0", y_valid, 1);
    s_valid = 1'b0;
    step();
    chk("b2_y1", y, 2);
    step();
    chk("b2_y2", y, 2);
    chk("b2_yl2", y_last, 1);

    // 4-sample frame 1,2,3,4 immediately after: y = 1,3,6,9,7,4.
    s_valid = 1'b1; s_data = 8'd1;
    step();
    chk("f4_y0", y, 1);
`ifdef FIR_FEED_SAMPLE_CNT_EN
    chk("cnt_first", frame_cnt, 1);
`endif
    s_data = 8'd2;
    step();
    chk("f4_y1", y, 3);
    s_data = 8'd3;
    step();
    chk("f4_y2", y, 6);
    s_data = 8'd4;
    step();
    chk("f4_y3", y, 9);
    s_valid = 1'b0;
    step();
    chk("f4_y4", y, 7);
    step();
    chk("f4_y5", y, 4);
    chk("f4_yl5", y_last, 1);
`ifdef FIR_FEED_SAMPLE_CNT_EN
    chk("cnt_at_last", frame_cnt, 4);
`endif
    step();
    chk("f4_idle_yv", y_valid, 0);
`ifdef FIR_FEED_SAMPLE_CNT_EN
    chk("cnt_held", frame_cnt, 4);
`endif

    // Next frame, then reset mid-frame.
    s_valid = 1'b1; s_data = 8'd4;
    step();
    chk("mid_x", x, 4);
    chk("mid_busy", busy, 1);
`ifdef FIR_FEED_SAMPLE_CNT_EN
    chk("cnt_restart", frame_cnt, 1);
`endif
    step();
    #2 rst = 1'b1;
    #1 chk("arst_x", x, 0);
    chk("arst_yv", y_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_c0", c0, 0);
    chk("arst_unloaded", s_ready, 0);
    step();
    rst = 1'b0; s_valid = 1'b0;
    step();
    chk("rel_cready", coef_ready, 1);
    chk("rel_sready", s_ready, 0);
    chk("rel_yl", y_last, 0);
`ifdef FIR_FEED_SAMPLE_CNT_EN
    chk("rel_cnt", frame_cnt, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
